// File: rtl/rom_ctrl_hash_feeder_if.sv
// Handshake bundle between the ROM read sweep, the feeder and the hash engine.
// The slave modport is the feeder's view; master is the environment driving it.
interface rom_ctrl_hash_feeder_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
);
    logic [DW-1:0] data;
    logic [AW-1:0] data_addr;
    logic          data_vld;
    logic          data_last_nontop;
    logic          data_rdy;
    logic [DW-1:0] kmac_data;
    logic          kmac_valid;
    logic          kmac_last;
    logic          kmac_ready;

    modport master (
        output data, data_addr, data_vld, data_last_nontop, kmac_ready,
        input  data_rdy, kmac_data, kmac_valid, kmac_last
    );

    modport slave (
        input  data, data_addr, data_vld, data_last_nontop, kmac_ready,
        output data_rdy, kmac_data, kmac_valid, kmac_last
    );
endinterface

// File: rtl/rom_ctrl_hash_feeder.sv
// Feeds non-top ROM words to the hash engine through a 2-entry FIFO and captures the top words
// as the expected digest. Define ROM_CTRL_FEEDER_ADDR_CHECK_EN to also check data_addr against the count.
module rom_ctrl_hash_feeder #(
    parameter int unsigned RomDepth    = 16,
    parameter int unsigned RomTopCount = 2,
    parameter int unsigned DW          = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    rom_ctrl_hash_feeder_if.slave     bus_io,
    output logic [RomTopCount*DW-1:0] exp_digest_o,
    output logic                      done_o,
    output logic                      err_o
);
    localparam int unsigned AW = (RomDepth > 1) ? $clog2(RomDepth) : 1;
    localparam int          NT = int'(RomDepth) - int'(RomTopCount);
    localparam logic [AW-1:0] LastNonTop = AW'(NT - 1);
    localparam logic [AW-1:0] LastWord   = AW'(RomDepth - 1);

    if (NT < 2) begin : gen_nt_check
        $fatal(1, "rom_ctrl_hash_feeder: RomDepth - RomTopCount must be at least 2");
    end

    typedef enum logic [1:0] {StHash, StTop, StDone, StErr} state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           fifo_data_q [2];
    logic [DW-1:0]           fifo_data_d [2];
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [RomTopCount*DW-1:0] digest_q, digest_d;
    logic                    top_full_q, top_full_d;

    logic accept, push, pop, capture, at_last_nontop, flag_err, addr_err;
    logic [1:0] cnt_after_pop;

`ifdef ROM_CTRL_FEEDER_ADDR_CHECK_EN
    assign addr_err = accept & (bus_io.data_addr != cnt_q);
`else
    logic unused_addr;
    assign unused_addr = ^bus_io.data_addr;
    assign addr_err    = 1'b0;
`endif

    always_comb begin
        bus_io.data_rdy   = ((state_q == StHash) && (fifo_cnt_q < 2'd2)) || (state_q == StTop);
        bus_io.kmac_valid = (state_q != StErr) && (fifo_cnt_q != 2'd0);
        bus_io.kmac_last  = bus_io.kmac_valid & fifo_last_q[0];
        bus_io.kmac_data  = fifo_data_q[0];
        exp_digest_o      = digest_q;
        done_o            = (state_q == StDone);
        err_o             = (state_q == StErr);
    end

    always_comb begin
        accept         = bus_io.data_vld & bus_io.data_rdy;
        pop            = bus_io.kmac_valid & bus_io.kmac_ready;
        push           = accept & (state_q == StHash);
        capture        = accept & (state_q == StTop) & ~top_full_q;
        at_last_nontop = (cnt_q == LastNonTop);
        // The last-non-top flag must agree with the running count in both directions
        flag_err       = push & (bus_io.data_last_nontop != at_last_nontop);

        fifo_data_d   = fifo_data_q;
        fifo_last_d   = fifo_last_q;
        cnt_after_pop = fifo_cnt_q - {1'b0, pop};
        if (pop) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
        end
        if (push) begin
            if (cnt_after_pop == 2'd0) begin
                fifo_data_d[0] = bus_io.data;
                fifo_last_d[0] = at_last_nontop;
            end else begin
                fifo_data_d[1] = bus_io.data;
                fifo_last_d[1] = at_last_nontop;
            end
        end
        fifo_cnt_d = cnt_after_pop + {1'b0, push};

        cnt_d = cnt_q;
        if (accept && (cnt_q != LastWord)) begin
            cnt_d = cnt_q + 1'b1;
        end

        digest_d   = digest_q;
        top_full_d = top_full_q;
        if (capture) begin
            for (int k = 0; k < int'(RomTopCount); k++) begin
                if (cnt_q == AW'(NT + k)) begin
                    digest_d[k*DW +: DW] = bus_io.data;
                end
            end
            if (cnt_q == LastWord) begin
                top_full_d = 1'b1;
            end
        end

        state_d = state_q;
        unique case (state_q)
            StHash: begin
                if (flag_err || addr_err) begin
                    state_d = StErr;
                end else if (push && bus_io.data_last_nontop) begin
                    state_d = StTop;
                end
            end
            StTop: begin
                if (addr_err) begin
                    state_d = StErr;
                end else if (top_full_d && (fifo_cnt_d == 2'd0)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StDone;
            StErr:  state_d = StErr;
        endcase

        if (state_d == StErr) begin
            fifo_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHash;
            cnt_q       <= '0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            fifo_cnt_q  <= '0;
            digest_q    <= '0;
            top_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
            digest_q    <= digest_d;
            top_full_q  <= top_full_d;
        end
    end
endmodule

// File: tb/tb_rom_ctrl_hash_feeder.sv
// Directed bench for rom_ctrl_hash_feeder with RomDepth=8, RomTopCount=2, DW=32.
module tb_rom_ctrl_hash_feeder;
    localparam int unsigned DW          = 32;
    localparam int unsigned RomDepth    = 8;
    localparam int unsigned RomTopCount = 2;
    localparam int unsigned AW          = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] digest;
    logic        done;
    logic        err;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] kq[$];
    logic        kl[$];

    always #5 clk = ~clk;

    rom_ctrl_hash_feeder_if #(.DW(DW), .AW(AW)) bus ();

    rom_ctrl_hash_feeder #(
        .RomDepth   (RomDepth),
        .RomTopCount(RomTopCount),
        .DW         (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_io      (bus),
        .exp_digest_o(digest),
        .done_o      (done),
        .err_o       (err)
    );

    // Record every word handed to the hash engine; inputs are stable from negedge to posedge
    always @(negedge clk) begin
        if (!rst && bus.kmac_valid && bus.kmac_ready) begin
            kq.push_back(bus.kmac_data);
            kl.push_back(bus.kmac_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_vld = 1'b0;
        bus.data_last_nontop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        kq.delete();
        kl.delete();
    endtask

    task automatic send(input int idx, input bit flag, input int addr);
        int n;
        bus.data             = 32'(32'hA0 + idx);
        bus.data_addr        = addr[2:0];
        bus.data_last_nontop = flag;
        bus.data_vld         = 1'b1;
        n = 0;
        while (!bus.data_rdy && n < 40) begin
            tick();
            n++;
        end
        if (!bus.data_rdy) chk("rdy_timeout", 64'(bus.data_rdy), 64'd1);
        tick();
        bus.data_vld         = 1'b0;
        bus.data_last_nontop = 1'b0;
    endtask

    task automatic check_sweep(input string tag);
        chk({tag, "_count"}, 64'(kq.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < kq.size()) begin
                chk($sformatf("%s_data%0d", tag, i), 64'(kq[i]), 64'(32'hA0 + i));
                chk($sformatf("%s_last%0d", tag, i), 64'(kl[i]), 64'(i == 5));
            end
        end
    endtask

    initial begin
        bus.kmac_ready       = 1'b1;
        bus.data             = '0;
        bus.data_addr        = '0;
        bus.data_vld         = 1'b0;
        bus.data_last_nontop = 1'b0;

        // Reset values
        do_reset();
        chk("rst_rdy", 64'(bus.data_rdy), 64'd1);
        chk("rst_valid", 64'(bus.kmac_valid), 64'd0);
        chk("rst_last", 64'(bus.kmac_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_digest", digest, 64'd0);

        // Full sweep, hash engine always ready
        for (int i = 0; i < 8; i++) begin
            send(i, i == 5, i);
            if (i == 6) chk("t1_done_early", 64'(done), 64'd0);
        end
        chk("t1_done_timing", 64'(done), 64'd1);
        tick();
        tick();
        check_sweep("t1");
        chk("t1_digest", digest, 64'h0000_00A7_0000_00A6);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_rdy", 64'(bus.data_rdy), 64'd0);
        chk("t1_valid", 64'(bus.kmac_valid), 64'd0);

        // Back-pressure: engine stalled for the first 6 cycles
        do_reset();
        bus.kmac_ready = 1'b0;
        send(0, 1'b0, 0);
        send(1, 1'b0, 1);
        chk("t2_rdy_full", 64'(bus.data_rdy), 64'd0);
        chk("t2_valid", 64'(bus.kmac_valid), 64'd1);
        chk("t2_head", 64'(bus.kmac_data), 64'h0000_00A0);
        for (int i = 0; i < 4; i++) tick();
        chk("t2_none_sent", 64'(kq.size()), 64'd0);
        bus.kmac_ready = 1'b1;
        for (int i = 2; i < 8; i++) send(i, i == 5, i);
        tick();
        tick();
        check_sweep("t2");
        chk("t2_digest", digest, 64'h0000_00A7_0000_00A6);
        chk("t2_done", 64'(done), 64'd1);

        // Premature last-non-top flag
        do_reset();
        send(0, 1'b0, 0);
        send(1, 1'b0, 1);
        send(2, 1'b0, 2);
        send(3, 1'b1, 3);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_rdy", 64'(bus.data_rdy), 64'd0);
        chk("t3_valid", 64'(bus.kmac_valid), 64'd0);
        chk("t3_done", 64'(done), 64'd0);
        tick();
        tick();
        tick();
        chk("t3_err_sticky", 64'(err), 64'd1);
        chk("t3_valid_later", 64'(bus.kmac_valid), 64'd0);
        chk("t3_sent", 64'(kq.size()), 64'd3);
        chk("t3_digest", digest, 64'd0);

        // Address sequence 0,1,3
        do_reset();
        send(0, 1'b0, 0);
        send(1, 1'b0, 1);
        send(2, 1'b0, 3);
`ifdef ROM_CTRL_FEEDER_ADDR_CHECK_EN
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_rdy", 64'(bus.data_rdy), 64'd0);
`else
        chk("t4_err", 64'(err), 64'd0);
        chk("t4_rdy", 64'(bus.data_rdy), 64'd1);
`endif

        // Reset in the middle of a sweep, then a fresh sweep
        do_reset();
        for (int i = 0; i < 5; i++) send(i, 1'b0, i);
        rst = 1'b1;
        kq.delete();
        kl.delete();
        tick();
        rst = 1'b0;
        chk("t5_rdy", 64'(bus.data_rdy), 64'd1);
        chk("t5_valid", 64'(bus.kmac_valid), 64'd0);
        chk("t5_last", 64'(bus.kmac_last), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_digest", digest, 64'd0);
        tick();
        tick();
        chk("t5_no_stale", 64'(kq.size()), 64'd0);
        for (int i = 0; i < 8; i++) send(i, i == 5, i);
        tick();
        tick();
        check_sweep("t5");
        chk("t5_digest_final", digest, 64'h0000_00A7_0000_00A6);
        chk("t5_done_final", 64'(done), 64'd1);
        chk("t5_err_final", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
